mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port data SRAM in the MIPS core. It shares one SRAM macro between the instruction-fetch path and the load/store path. Each cycle it grants at most one requester and drives the SRAM chip/write/output enables, address and write data from registers. It then returns read data to the requester that issued the access. It sits between the core (IR_addr/IR side and load/store side) and the SRAM, so instruction and data memory can live in one array.

---
 rtl/mem_port_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and load/store, with a
// bounded data-priority streak so a pending fetch is never starved.
module mem_port_arbiter #(
    parameter int unsigned AW         = 7,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          CEN,
    output logic          WEN,
    output logic          OEN,
    output logic [AW-1:0] A,
    output logic [31:0]   D,
    input  logic [31:0]   Q
);

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2,
        OWN_STORE = 2'd3
    } owner_e;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    logic [3:0]    streak_q, streak_d;
    logic          streak_full_s;
    logic          if_gnt_s, d_gnt_s;
    logic          cen_q, cen_d;
    logic          wen_q, wen_d;
    logic          oen_q, oen_d;
    logic [AW-1:0] a_q, a_d;
    logic [31:0]   d_q, d_d;
    owner_e        cmd_owner_q, cmd_owner_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic          unused_addr_bits_s;

    // Byte-lane bits and bits above the SRAM depth are ignored (addresses alias).
    assign unused_addr_bits_s = ^{if_addr[31:AW+2], if_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

    // Per-cycle arbitration: data wins unless the streak limit is reached.
    always_comb begin
        streak_full_s = (streak_q == STREAK_MAX);
        if_gnt_s      = 1'b0;
        d_gnt_s       = 1'b0;
        if (if_req && d_req) begin
            if (streak_full_s) begin
                if_gnt_s = 1'b1;
            end else begin
                d_gnt_s = 1'b1;
            end
        end else if (if_req) begin
            if_gnt_s = 1'b1;
        end else if (d_req) begin
            d_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
        end
    end

    // Command-stage next state: SRAM controls, address, write data and owner tag.
    always_comb begin
        cen_d       = 1'b1;
        wen_d       = 1'b1;
        a_d         = a_q;
        d_d         = d_q;
        cmd_owner_d = OWN_IDLE;
        if (if_gnt_s) begin
            cen_d       = 1'b0;
            a_d         = if_addr[AW+1:2];
            cmd_owner_d = OWN_FETCH;
        end else if (d_gnt_s) begin
            cen_d = 1'b0;
            wen_d = ~d_we;
            a_d   = d_addr[AW+1:2];
            if (d_we) begin
                d_d         = d_wdata;
                cmd_owner_d = OWN_STORE;
            end else begin
                cmd_owner_d = OWN_LOAD;
            end
        end else begin
            cmd_owner_d = OWN_IDLE;
        end
    end

    // Streak only grows while a fetch is actually waiting behind data grants.
    always_comb begin
        streak_d = streak_q;
        if (!if_req || if_gnt_s) begin
            streak_d = 4'd0;
        end else if (d_gnt_s && !streak_full_s) begin
            streak_d = streak_q + 4'd1;
        end else begin
            streak_d = streak_q;
        end
    end

    // Return-stage next state: SRAM data appears one cycle after the command.
    always_comb begin
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        case (cmd_owner_q)
            OWN_FETCH: if_rvalid_d = 1'b1;
            OWN_LOAD:  d_rvalid_d  = 1'b1;
            default: begin
                if_rvalid_d = 1'b0;
                d_rvalid_d  = 1'b0;
            end
        endcase
        oen_d = ~(if_rvalid_d | d_rvalid_d);
    end

    // Two-stage owner pipeline plus registered SRAM interface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q    <= 4'd0;
            cen_q       <= 1'b1;
            wen_q       <= 1'b1;
            oen_q       <= 1'b1;
            a_q         <= '0;
            d_q         <= 32'd0;
            cmd_owner_q <= OWN_IDLE;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            streak_q    <= streak_d;
            cen_q       <= cen_d;
            wen_q       <= wen_d;
            oen_q       <= oen_d;
            a_q         <= a_d;
            d_q         <= d_d;
            cmd_owner_q <= cmd_owner_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
        end
    end

    assign if_gnt    = if_gnt_s;
    assign d_gnt     = d_gnt_s;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = Q;
    assign d_rdata   = Q;
    assign CEN       = cen_q;
    assign WEN       = wen_q;
    assign OEN       = oen_q;
    assign A         = a_q;
    assign D         = d_q;

    mem_port_arbiter_checker #(
        .STREAK_MAX(STREAK_MAX)
    ) u_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .d_req     (d_req),
        .if_gnt    (if_gnt_s),
        .d_gnt     (d_gnt_s),
        .if_rvalid (if_rvalid_q),
        .d_rvalid  (d_rvalid_q),
        .oen       (oen_q),
        .streak    (streak_q)
    );

endmodule

// Protocol invariants of the arbiter: mutual exclusion, grant qualification,
// streak bound and output-enable / rvalid consistency.
module mem_port_arbiter_checker #(
    parameter logic [3:0] STREAK_MAX = 4'd4
) (
    input logic       clk,
    input logic       rst_n,
    input logic       if_req,
    input logic       d_req,
    input logic       if_gnt,
    input logic       d_gnt,
    input logic       if_rvalid,
    input logic       d_rvalid,
    input logic       oen,
    input logic [3:0] streak
);

    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n) !(if_gnt && d_gnt));
    a_if_qual:   assert property (@(posedge clk) disable iff (!rst_n) if_gnt |-> if_req);
    a_d_qual:    assert property (@(posedge clk) disable iff (!rst_n) d_gnt |-> d_req);
    a_streak:    assert property (@(posedge clk) disable iff (!rst_n) streak <= STREAK_MAX);
    a_one_ret:   assert property (@(posedge clk) disable iff (!rst_n) !(if_rvalid && d_rvalid));
    a_oen:       assert property (@(posedge clk) disable iff (!rst_n) oen == !(if_rvalid || d_rvalid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: arbitration table, hand-written
// corner sequences and a randomized run against a schedule-based reference model.
module tb_mem_port_arbiter;

    localparam int AW    = 7;
    localparam int MAXS  = 4;
    localparam int WORDS = 1 << AW;
    localparam int NRAND = 600;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          CEN;
    logic          WEN;
    logic          OEN;
    logic [AW-1:0] A;
    logic [31:0]   D;
    logic [31:0]   Q;

    logic [31:0] sram    [0:WORDS-1];
    logic [31:0] ref_mem [0:WORDS-1];
    logic        mem_init;
    int          vectors     = 0;
    int          miscompares = 0;

    typedef struct packed {
        logic ifr;
        logic dr;
        logic eig;
        logic edg;
    } arb_vec_t;

    localparam arb_vec_t VD = 4'b1101;
    localparam arb_vec_t VI = 4'b1110;
    localparam arb_vec_t VF = 4'b1010;
    localparam arb_vec_t VL = 4'b0101;
    localparam arb_vec_t VN = 4'b0000;

    arb_vec_t tbl [0:25];

    logic        sch_cen  [0:NRAND+2];
    logic        sch_wen  [0:NRAND+2];
    logic        sch_oen  [0:NRAND+2];
    logic        sch_ifv  [0:NRAND+2];
    logic        sch_dv   [0:NRAND+2];
    logic [31:0] sch_a    [0:NRAND+2];
    logic [31:0] sch_d    [0:NRAND+2];
    logic [31:0] sch_data [0:NRAND+2];

    mem_port_arbiter #(.AW(AW), .MAX_STREAK(MAXS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .CEN       (CEN),
        .WEN       (WEN),
        .OEN       (OEN),
        .A         (A),
        .D         (D),
        .Q         (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0013);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % 32'(WORDS));
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        if ($urandom_range(0, 1) == 1) begin
            r = $urandom;
        end else begin
            r = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        end
        return r;
    endfunction

    // Single-port synchronous SRAM model: write or read on CEN low.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < WORDS; i++) sram[i] <= pat(i);
        end else if (!CEN) begin
            if (!WEN) sram[A] <= D;
            else      Q <= sram[A];
        end
    end

    task automatic check1(input string name, input logic act, input logic exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        if_req   = 1'b0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        mem_init = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        rst_n    = 1'b1;
    endtask

    initial begin
        logic        prev_g;
        logic        ip, dp, dw, eig, edg;
        logic [31:0] ia, da, dwd;
        int          s, w;

        tbl = '{VD, VD, VD, VD, VI, VD, VD, VD, VD, VI,
                VF, VD, VF, VD, VF,
                VL, VL, VL, VL, VL,
                VD, VD, VD, VD, VI, VN};

        // Reset held with a fetch pending, then the fetch of aliased address 0x200.
        rst_n    = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h0000_0200;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = 32'd0;
        d_wdata  = 32'd0;
        mem_init = 1'b1;
        @(negedge clk);
        #1;
        check1("rst_cen", CEN, 1'b1);
        check1("rst_wen", WEN, 1'b1);
        check1("rst_oen", OEN, 1'b1);
        check32("rst_a", 32'(A), 32'd0);
        check32("rst_d", D, 32'd0);
        check1("rst_if_rvalid", if_rvalid, 1'b0);
        check1("rst_d_rvalid", d_rvalid, 1'b0);
        check1("rst_if_gnt_comb", if_gnt, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        check1("rst_cen_hold", CEN, 1'b1);
        mem_init = 1'b0;
        rst_n    = 1'b1;
        #1;
        check1("post_rst_if_gnt", if_gnt, 1'b1);
        check1("post_rst_d_gnt", d_gnt, 1'b0);
        @(posedge clk);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        check1("fetch_cmd_cen", CEN, 1'b0);
        check1("fetch_cmd_wen", WEN, 1'b1);
        check32("fetch_alias_a", 32'(A), 32'd0);
        check1("fetch_cmd_rvalid", if_rvalid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check1("fetch_ret_rvalid", if_rvalid, 1'b1);
        check1("fetch_ret_oen", OEN, 1'b0);
        check32("fetch_ret_rdata", if_rdata, pat(0));
        check1("fetch_ret_d_rvalid", d_rvalid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check1("fetch_after_rvalid", if_rvalid, 1'b0);
        check1("fetch_after_oen", OEN, 1'b1);
        check1("fetch_after_cen", CEN, 1'b1);

        // Store then load the same address back-to-back.
        do_reset();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0010;
        d_wdata = 32'hDEAD_BEEF;
        #1;
        check1("st_gnt", d_gnt, 1'b1);
        @(posedge clk);
        @(negedge clk);
        d_we = 1'b0;
        #1;
        check1("ld_gnt", d_gnt, 1'b1);
        check1("st_cen", CEN, 1'b0);
        check1("st_wen", WEN, 1'b0);
        check32("st_a", 32'(A), 32'd4);
        check32("st_d", D, 32'hDEAD_BEEF);
        @(posedge clk);
        @(negedge clk);
        d_req = 1'b0;
        #1;
        check1("ld_cen", CEN, 1'b0);
        check1("ld_wen", WEN, 1'b1);
        check32("ld_a", 32'(A), 32'd4);
        check1("st_no_rvalid", d_rvalid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check1("raw_rvalid", d_rvalid, 1'b1);
        check32("raw_rdata", d_rdata, 32'hDEAD_BEEF);
        check1("raw_oen", OEN, 1'b0);

        // Reset lands while a load is in flight: its return must be dropped.
        do_reset();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0020;
        #1;
        check1("mid_ld_gnt", d_gnt, 1'b1);
        @(posedge clk);
        @(negedge clk);
        d_req = 1'b0;
        #1;
        check1("mid_cmd_cen", CEN, 1'b0);
        rst_n = 1'b0;
        #1;
        check1("mid_rst_cen", CEN, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        check1("mid_rst_rvalid", d_rvalid, 1'b0);
        check1("mid_rst_cen2", CEN, 1'b1);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check1("mid_post_rvalid", d_rvalid, 1'b0);
            check1("mid_post_oen", OEN, 1'b1);
        end

        // Arbitration / streak table.
        do_reset();
        prev_g = 1'b0;
        for (int k = 0; k < 26; k++) begin
            if_req  = tbl[k].ifr;
            d_req   = tbl[k].dr;
            d_we    = 1'b0;
            d_addr  = 32'(k * 4);
            if_addr = 32'(k * 4 + 256);
            #1;
            check1("tbl_if_gnt", if_gnt, tbl[k].eig);
            check1("tbl_d_gnt", d_gnt, tbl[k].edg);
            check1("tbl_cen", CEN, ~prev_g);
            prev_g = tbl[k].eig | tbl[k].edg;
            @(posedge clk);
            @(negedge clk);
        end

        // Randomized run against a cycle-indexed expectation schedule.
        do_reset();
        for (int i = 0; i < WORDS; i++) ref_mem[i] = pat(i);
        for (int t = 0; t <= NRAND + 2; t++) begin
            sch_cen[t] = 1'b1;
            sch_wen[t] = 1'b1;
            sch_oen[t] = 1'b1;
            sch_ifv[t] = 1'b0;
            sch_dv[t]  = 1'b0;
            sch_a[t]   = 32'd0;
            sch_d[t]   = 32'd0;
            sch_data[t] = 32'd0;
        end
        ip  = 1'b0;
        dp  = 1'b0;
        dw  = 1'b0;
        ia  = 32'd0;
        da  = 32'd0;
        dwd = 32'd0;
        s   = 0;
        for (int t = 0; t < NRAND; t++) begin
            #1;
            check1("rnd_cen", CEN, sch_cen[t]);
            check1("rnd_wen", WEN, sch_wen[t]);
            check1("rnd_oen", OEN, sch_oen[t]);
            check32("rnd_a", 32'(A), sch_a[t]);
            check32("rnd_d", D, sch_d[t]);
            check1("rnd_if_rvalid", if_rvalid, sch_ifv[t]);
            check1("rnd_d_rvalid", d_rvalid, sch_dv[t]);
            if (sch_ifv[t]) check32("rnd_if_rdata", if_rdata, sch_data[t]);
            if (sch_dv[t])  check32("rnd_d_rdata", d_rdata, sch_data[t]);

            if (!ip && $urandom_range(0, 3) != 0) begin
                ip = 1'b1;
                ia = rand_addr();
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp  = 1'b1;
                dw  = 1'($urandom_range(0, 1));
                da  = rand_addr();
                dwd = $urandom;
            end
            if_req  = ip;
            if_addr = ia;
            d_req   = dp;
            d_we    = dw;
            d_addr  = da;
            d_wdata = dwd;
            #1;
            eig = ip && (!dp || s == MAXS);
            edg = dp && !eig;
            check1("rnd_if_gnt", if_gnt, eig);
            check1("rnd_d_gnt", d_gnt, edg);

            sch_a[t+1]   = sch_a[t];
            sch_d[t+1]   = sch_d[t];
            sch_cen[t+1] = 1'b1;
            sch_wen[t+1] = 1'b1;
            if (eig) begin
                w = word_of(ia);
                sch_cen[t+1]  = 1'b0;
                sch_a[t+1]    = 32'(w);
                sch_ifv[t+2]  = 1'b1;
                sch_oen[t+2]  = 1'b0;
                sch_data[t+2] = ref_mem[w];
                ip = 1'b0;
            end else if (edg) begin
                w = word_of(da);
                sch_cen[t+1] = 1'b0;
                sch_a[t+1]   = 32'(w);
                sch_wen[t+1] = ~dw;
                if (dw) begin
                    sch_d[t+1] = dwd;
                    ref_mem[w] = dwd;
                end else begin
                    sch_dv[t+2]   = 1'b1;
                    sch_oen[t+2]  = 1'b0;
                    sch_data[t+2] = ref_mem[w];
                end
                dp = 1'b0;
            end

            if (!if_req || eig) s = 0;
            else if (edg && s < MAXS) s = s + 1;

            @(posedge clk);
            @(negedge clk);
        end
        if_req = 1'b0;
        d_req  = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
